// File: rtl/lcd_post_pkg.sv
// Shared definitions for the POST-code to character-LCD bridge:
// received byte field layout, long-running HD44780 command codes, sequencer states.
package lcd_post_pkg;
  localparam int BIT_CTRL = 0;
  localparam int SEL_LSB  = 1;
  localparam int RS_BIT   = 3;
  localparam int NIB_LSB  = 4;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} seq_state_t;

  // Commands that need the long lockout before the controller accepts more.
  function automatic logic is_long_code(input logic [7:0] c);
    return (c == CMD_CLEAR) || (c == CMD_HOME) || (c == CMD_HOME_ALT);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; full/empty/ready are registered from the next occupancy.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt, cnt_nxt;
  logic             do_wr, do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rptr];

  always_comb begin
    cnt_nxt = cnt;
    if (do_wr && !do_rd)      cnt_nxt = cnt + (AW+1)'(1);
    else if (do_rd && !do_wr) cnt_nxt = cnt - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  // ready stays low through reset and rises on the first clock after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      ready <= 1'b0;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == FULL_CNT);
      empty <= (cnt_nxt == '0);
      ready <= (cnt_nxt != FULL_CNT);
    end
  end
endmodule

// File: rtl/lcd_post_bridge.sv
// Buffers received POST bytes and replays them as 4-bit HD44780 writes with
// setup/pulse/hold timing and a post-write lockout sized per command.
module lcd_post_bridge
  import lcd_post_pkg::*;
#(
  parameter int CLK_MHZ  = 12,
  parameter int DEPTH    = 8,
  parameter int NUM_E    = 2,
  parameter int T_SU     = 1,
  parameter int T_PW     = 6,
  parameter int T_H      = 1,
  parameter int SHORT_US = 50,
  parameter int LONG_US  = 2000
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_strobe,
  output logic             rx_ready,
  output logic             overflow,
  output logic [3:0]       lcd_dq,
  output logic             lcd_rs,
  output logic [NUM_E-1:0] lcd_e,
  output logic             busy
);
  localparam int SHORT_N = SHORT_US * CLK_MHZ;
  localparam int LONG_N  = LONG_US * CLK_MHZ;
  localparam int CW      = $clog2(LONG_N + 1);
  localparam logic [CW-1:0] SHORT_C = CW'(SHORT_N);
  localparam logic [CW-1:0] LONG_C  = CW'(LONG_N);
  localparam logic [CW-1:0] SU_C    = CW'(T_SU - 1);
  localparam logic [CW-1:0] PW_C    = CW'(T_PW - 1);
  localparam logic [CW-1:0] H_C     = CW'(T_H - 1);
  localparam logic [2:0]    NE      = 3'(NUM_E);

  logic [7:0]      fb;
  logic            fifo_full, fifo_empty, push, pop;
  seq_state_t      state;
  logic [CW-1:0]   cnt;
  logic [1:0]      sel_q;
  logic            long_q;
  logic [3:0]      phase;
  logic [3:0][3:0] hi_nib;
  logic [3:0]      nib;
  logic [1:0]      sel;
  logic            wr_ok, wr_long;

  assign push = rx_strobe && rx_ready && !fifo_full;
  assign pop  = (state == S_IDLE) && !fifo_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk(refclk), .rst(rst), .wr_en(push), .wr_data(rx_data), .rd_en(pop),
    .rd_data(fb), .full(fifo_full), .empty(fifo_empty), .ready(rx_ready)
  );

  assign nib     = fb[NIB_LSB +: 4];
  assign sel     = fb[SEL_LSB +: 2];
  assign wr_ok   = !fb[BIT_CTRL] && ({1'b0, sel} < NE);
  // phase high means this write carries the high nibble of a byte.
  assign wr_long = !fb[RS_BIT] && !phase[sel] && is_long_code({hi_nib[sel], nib});

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else if (rx_strobe && !rx_ready) overflow <= 1'b1;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      sel_q  <= '0;
      long_q <= 1'b0;
      phase  <= '1;
      hi_nib <= '0;
      lcd_dq <= '0;
      lcd_rs <= 1'b0;
      lcd_e  <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (pop) begin
          if (wr_ok) begin
            lcd_dq       <= nib;
            lcd_rs       <= fb[RS_BIT];
            sel_q        <= sel;
            long_q       <= wr_long;
            phase[sel]   <= ~phase[sel];
            if (phase[sel]) hi_nib[sel] <= nib;
            cnt          <= SU_C;
            busy         <= 1'b1;
            state        <= S_SETUP;
          end else if (fb[BIT_CTRL] && nib == 4'h0) begin
            phase <= '1;
          end
        end
        S_SETUP: if (cnt == '0) begin
          lcd_e <= NUM_E'(1) << sel_q;
          cnt   <= PW_C;
          state <= S_PULSE;
        end else cnt <= cnt - CW'(1);
        S_PULSE: if (cnt == '0) begin
          lcd_e <= '0;
          cnt   <= H_C;
          state <= S_HOLD;
        end else cnt <= cnt - CW'(1);
        S_HOLD: if (cnt == '0) begin
          cnt   <= long_q ? LONG_C : SHORT_C;
          state <= S_WAIT;
        end else cnt <= cnt - CW'(1);
        // Counts the lockout down to zero; the zero cycle is the last busy cycle.
        S_WAIT: if (cnt == '0) begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end else cnt <= cnt - CW'(1);
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_post_bridge.sv
// Bench for lcd_post_bridge: directed scenarios plus random bytes, checked against
// a byte-level model of which LCD writes must appear and how long each lockout is.
module tb_lcd_post_bridge;
  localparam int CLK_MHZ = 12, DEPTH = 8, NUM_E = 2;
  localparam int T_SU = 1, T_PW = 6, T_H = 1, SHORT_US = 50, LONG_US = 2000;

  logic             refclk = 1'b0;
  logic             rst;
  logic [7:0]       rx_data;
  logic             rx_strobe;
  logic             rx_ready, overflow, lcd_rs, busy;
  logic [3:0]       lcd_dq;
  logic [NUM_E-1:0] lcd_e;

  lcd_post_bridge #(
    .CLK_MHZ(CLK_MHZ), .DEPTH(DEPTH), .NUM_E(NUM_E), .T_SU(T_SU), .T_PW(T_PW),
    .T_H(T_H), .SHORT_US(SHORT_US), .LONG_US(LONG_US)
  ) dut (
    .refclk(refclk), .rst(rst), .rx_data(rx_data), .rx_strobe(rx_strobe),
    .rx_ready(rx_ready), .overflow(overflow), .lcd_dq(lcd_dq), .lcd_rs(lcd_rs),
    .lcd_e(lcd_e), .busy(busy)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic [3:0] dq;
    logic       rs;
    logic [1:0] sel;
    int         wait_n;
  } txn_t;

  txn_t             exp_q[$];
  logic [3:0]       m_ph;
  logic [3:0]       m_hi [4];
  int               total = 0, bad = 0;
  int               last_busy = 0, ntx = 0, e_idle_err = 0;
  logic [NUM_E-1:0] last_mask = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = '1;
    for (int k = 0; k < 4; k++) m_hi[k] = 4'h0;
  endtask

  // Each channel alternates high/low nibble; a low-nibble RS=0 write completing
  // byte 0x01..0x03 is a clear/home command and gets the long lockout.
  task automatic model_push(input logic [7:0] b);
    txn_t t;
    int   s, code;
    s = int'(b[2:1]);
    if (!b[0]) begin
      if (s < NUM_E) begin
        code     = int'(m_hi[s]) * 16 + int'(b[7:4]);
        t.dq     = b[7:4];
        t.rs     = b[3];
        t.sel    = b[2:1];
        t.wait_n = (!b[3] && !m_ph[s] && code >= 1 && code <= 3) ?
                   LONG_US * CLK_MHZ : SHORT_US * CLK_MHZ;
        if (m_ph[s]) m_hi[s] = b[7:4];
        m_ph[s] = !m_ph[s];
        exp_q.push_back(t);
      end
    end else if (b[7:4] == 4'h0) begin
      m_ph = '1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge refclk);
    rx_data   = b;
    rx_strobe = 1'b1;
    if (rx_ready) model_push(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge refclk);
      rx_strobe = 1'b0;
    end
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    @(negedge refclk);
    rx_strobe = 1'b0;
    while ((exp_q.size() != 0 || busy) && n < maxc) begin
      @(negedge refclk);
      n++;
    end
    chk("drain_timeout", n >= maxc, 0);
    idle(3);
  endtask

  // Observes each busy window and compares it with the oldest expected write.
  task automatic monitor();
    bit               in_txn, seen_e, unstable;
    int               blen, su, elen;
    logic [3:0]       mdq;
    logic             mrs;
    logic [NUM_E-1:0] mmask;
    txn_t             t;
    in_txn = 0; seen_e = 0; unstable = 0; blen = 0; su = 0; elen = 0;
    mdq = '0; mrs = 1'b0; mmask = '0;
    forever begin
      @(negedge refclk);
      if (rst) in_txn = 0;
      else begin
        if (!busy && lcd_e != '0) e_idle_err++;
        if (busy) begin
          if (!in_txn) begin
            in_txn = 1; blen = 0; su = 0; elen = 0; seen_e = 0; unstable = 0;
            mdq = lcd_dq; mrs = lcd_rs; mmask = '0;
          end
          blen++;
          if (lcd_dq !== mdq || lcd_rs !== mrs) unstable = 1;
          if (lcd_e != '0) begin
            elen++;
            if (!seen_e) mmask = lcd_e;
            else if (lcd_e !== mmask) unstable = 1;
            seen_e = 1;
          end else if (!seen_e) su++;
        end else if (in_txn) begin
          in_txn    = 0;
          last_busy = blen;
          last_mask = mmask;
          ntx++;
          if (exp_q.size() == 0) chk("txn_extra", 1, 0);
          else begin
            t = exp_q.pop_front();
            chk("dq", mdq, t.dq);
            chk("rs", mrs, t.rs);
            chk("e_mask", mmask, 32'(1) << t.sel);
            chk("setup_len", su, T_SU);
            chk("pulse_len", elen, T_PW);
            chk("busy_len", blen, 1 + T_SU + T_PW + T_H + t.wait_n);
            chk("stable", unstable, 0);
          end
        end
      end
    end
  endtask

  initial begin
    logic [7:0] rb;
    int         n, n0;
    rst = 1'b1; rx_strobe = 1'b0; rx_data = 8'h00;
    model_reset();
    fork monitor(); join_none

    // reset values and first-edge rx_ready
    idle(2);
    chk("rst_dq", lcd_dq, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_e", lcd_e, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ready", rx_ready, 0);
    rst = 1'b0;
    chk("ready_pre_edge", rx_ready, 0);
    idle(1);
    chk("ready_post_edge", rx_ready, 1);

    // single data write: latency and full busy window
    push(8'h58);
    @(negedge refclk);
    rx_strobe = 1'b0;
    chk("lat_not_yet", busy, 0);
    @(negedge refclk);
    chk("lat_busy", busy, 1);
    wait_idle(2000);
    chk("short_busy", last_busy, 1 + 1 + 6 + 1 + 600);
    chk("short_mask", last_mask, 1);

    // fresh phase: 0x00 then 0x10 forms clear-display
    push(8'h01);
    push(8'h00);
    push(8'h10);
    wait_idle(30000);
    chk("long_busy", last_busy, 1 + 1 + 6 + 1 + 24000);

    // second controller, then an out-of-range select that must be swallowed
    push(8'h02);
    wait_idle(2000);
    chk("e1_mask", last_mask, 2);
    n0 = ntx;
    push(8'h04);
    wait_idle(50);
    chk("bad_sel_quiet", ntx, n0);

    // phase reset between pairs
    push(8'h10);
    push(8'h01);
    push(8'h00);
    push(8'h10);
    wait_idle(30000);
    chk("phase_rst_long", last_busy, 1 + 1 + 6 + 1 + 24000);

    // overflow with a stalled sequencer
    push(8'h58);
    idle(3);
    for (int i = 0; i < 9; i++) begin
      push((i % 2 == 1) ? 8'h5A : 8'h58);
      if (i == 7) chk("ready_8th", rx_ready, 1);
      if (i == 8) begin
        chk("ready_full", rx_ready, 0);
        chk("ovf_pre", overflow, 0);
      end
    end
    idle(1);
    chk("ovf_set", overflow, 1);
    idle(50);
    chk("ovf_sticky", overflow, 1);

    // reset in the middle of an enable pulse
    n = 0;
    while (lcd_e == '0 && n < 3000) begin
      @(negedge refclk);
      n++;
    end
    chk("pulse_seen", lcd_e != '0, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_e", lcd_e, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_ready", rx_ready, 0);
    chk("rst_async_ovf", overflow, 0);
    exp_q.delete();
    model_reset();
    idle(2);
    rst = 1'b0;
    chk("rel_ready_pre", rx_ready, 0);
    idle(1);
    chk("rel_ready", rx_ready, 1);
    chk("rel_busy", busy, 0);
    n0 = ntx;
    idle(20);
    chk("rel_fifo_empty", ntx, n0);
    chk("rel_busy_late", busy, 0);

    // random bytes; long commands are steered away to keep the run short
    for (int i = 0; i < 20; i++) begin
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) rb[0] = 1'b0;
      if (i % 7 == 6) rb = 8'h01;
      if (!rb[0] && int'(rb[2:1]) < NUM_E && !m_ph[rb[2:1]] && m_hi[rb[2:1]] == 4'h0 &&
          rb[7:4] >= 4'h1 && rb[7:4] <= 4'h3) rb[3] = 1'b1;
      push(rb);
      idle($urandom_range(1, 300));
    end
    wait_idle(30000);

    chk("queue_empty", exp_q.size(), 0);
    chk("e_idle", e_idle_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
